// File: rtl/l1_mem_arb.sv
// l1_mem_arb: round-robin arbiter that puts L1 I$ line fills and D$ word accesses onto one memory port.
// Optional bus watchdog is built only when MEM_ARB_TIMEOUT_EN is defined.
module l1_mem_arb #(
    parameter int PC_SZ       = 32,
    parameter int RSZ         = 32,
    parameter int CL_LEN      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  ic_req,
    input  logic [PC_SZ-1:0]      ic_addr,
    output logic                  ic_ack,
    output logic [CL_LEN*8-1:0]   ic_ack_data,
    output logic                  ic_ack_fault,
    input  logic                  dc_req,
    input  logic [PC_SZ-1:0]      dc_addr,
    input  logic                  dc_wr,
    input  logic [RSZ-1:0]        dc_wr_data,
    output logic                  dc_ack,
    output logic [RSZ-1:0]        dc_ack_data,
    output logic                  dc_ack_fault,
    output logic                  mem_req,
    output logic [PC_SZ-1:0]      mem_addr,
    output logic                  mem_wr,
    output logic [RSZ-1:0]        mem_wr_data,
    output logic                  mem_src,
    input  logic                  mem_ack,
    input  logic [CL_LEN*8-1:0]   mem_ack_data,
    input  logic                  mem_ack_fault
);

    localparam int LINE_W = CL_LEN * 8;
    localparam int WORDS  = CL_LEN / 4;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (CL_LEN < 4 || (CL_LEN & (CL_LEN - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("l1_mem_arb: CL_LEN must be a power of 2 >= 4 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                rr_last_q, rr_last_d;  // 1: D$ owned the last transaction
    logic                mem_req_q, mem_req_d;
    logic [PC_SZ-1:0]    mem_addr_q, mem_addr_d;
    logic                mem_wr_q, mem_wr_d;
    logic [RSZ-1:0]      mem_wr_data_q, mem_wr_data_d;
    logic                mem_src_q, mem_src_d;
    logic                ic_ack_q, ic_ack_d;
    logic [LINE_W-1:0]   ic_ack_data_q, ic_ack_data_d;
    logic                ic_ack_fault_q, ic_ack_fault_d;
    logic                dc_ack_q, dc_ack_d;
    logic [RSZ-1:0]      dc_ack_data_q, dc_ack_data_d;
    logic                dc_ack_fault_q, dc_ack_fault_d;

    logic                grant_i, grant_d;
    logic                finish_txn, use_bus_data, resp_fault;
    logic [IDX_W-1:0]    word_idx;
    logic [RSZ-1:0]      line_words [2**IDX_W];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [WD_W-1:0]     wdog_q, wdog_d;
`endif

    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_words
        if (i < WORDS) begin : g_used
            assign line_words[i] = mem_ack_data[i*RSZ +: RSZ];
        end else begin : g_pad
            assign line_words[i] = '0;
        end
    end

    // Word offset comes from the registered address, never from the live D$ port.
    assign word_idx = (WORDS > 1) ? mem_addr_q[IDX_W+1:2] : '0;

    // A tie goes to whoever was not served last.
    assign grant_i = ic_req && (!dc_req || rr_last_q);
    assign grant_d = dc_req && (!ic_req || !rr_last_q);

    always_comb begin
        state_d        = state_q;
        rr_last_d      = rr_last_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        mem_wr_d       = mem_wr_q;
        mem_wr_data_d  = mem_wr_data_q;
        mem_src_d      = mem_src_q;
        ic_ack_d       = 1'b0;
        ic_ack_data_d  = '0;
        ic_ack_fault_d = 1'b0;
        dc_ack_d       = 1'b0;
        dc_ack_data_d  = '0;
        dc_ack_fault_d = 1'b0;
        finish_txn     = 1'b0;
        use_bus_data   = 1'b0;
        resp_fault     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wdog_d         = wdog_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d       = GNT_I;
                    mem_req_d     = 1'b1;
                    mem_addr_d    = ic_addr;
                    mem_wr_d      = 1'b0;
                    mem_wr_data_d = '0;
                    mem_src_d     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    wdog_d        = '0;
`endif
                end else if (grant_d) begin
                    state_d       = GNT_D;
                    mem_req_d     = 1'b1;
                    mem_addr_d    = dc_addr;
                    mem_wr_d      = dc_wr;
                    mem_wr_data_d = dc_wr_data;
                    mem_src_d     = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    wdog_d        = '0;
`endif
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    finish_txn   = 1'b1;
                    use_bus_data = 1'b1;
                    resp_fault   = mem_ack_fault;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYC)) begin
                    finish_txn = 1'b1;
                    resp_fault = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
                if (finish_txn) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    rr_last_d = (state_q == GNT_D);
                    if (state_q == GNT_I) begin
                        ic_ack_d       = 1'b1;
                        ic_ack_data_d  = use_bus_data ? mem_ack_data : '0;
                        ic_ack_fault_d = resp_fault;
                    end else begin
                        dc_ack_d       = 1'b1;
                        dc_ack_data_d  = use_bus_data ? line_words[word_idx] : '0;
                        dc_ack_fault_d = resp_fault;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            rr_last_q      <= 1'b1;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_q       <= 1'b0;
            mem_wr_data_q  <= '0;
            mem_src_q      <= 1'b0;
            ic_ack_q       <= 1'b0;
            ic_ack_data_q  <= '0;
            ic_ack_fault_q <= 1'b0;
            dc_ack_q       <= 1'b0;
            dc_ack_data_q  <= '0;
            dc_ack_fault_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rr_last_q      <= rr_last_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_q       <= mem_wr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            mem_src_q      <= mem_src_d;
            ic_ack_q       <= ic_ack_d;
            ic_ack_data_q  <= ic_ack_data_d;
            ic_ack_fault_q <= ic_ack_fault_d;
            dc_ack_q       <= dc_ack_d;
            dc_ack_data_q  <= dc_ack_data_d;
            dc_ack_fault_q <= dc_ack_fault_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q         <= wdog_d;
`endif
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wr       = mem_wr_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign mem_src      = mem_src_q;
    assign ic_ack       = ic_ack_q;
    assign ic_ack_data  = ic_ack_data_q;
    assign ic_ack_fault = ic_ack_fault_q;
    assign dc_ack       = dc_ack_q;
    assign dc_ack_data  = dc_ack_data_q;
    assign dc_ack_fault = dc_ack_fault_q;

endmodule

// File: tb/tb_l1_mem_arb.sv
// Randomized bench for l1_mem_arb against a transaction-level model of the arbitration rules.
// Defining MEM_ARB_TIMEOUT_EN also exercises the watchdog with a 4-cycle limit.
module tb_l1_mem_arb;
    localparam int PC_SZ  = 32;
    localparam int RSZ    = 32;
    localparam int CL_LEN = 32;
    localparam int LW     = CL_LEN * 8;
    localparam int WORDS  = CL_LEN / 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif
    localparam int NCYC = 3000;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              ic_req, ic_ack, ic_ack_fault;
    logic [PC_SZ-1:0]  ic_addr;
    logic [LW-1:0]     ic_ack_data;
    logic              dc_req, dc_wr, dc_ack, dc_ack_fault;
    logic [PC_SZ-1:0]  dc_addr;
    logic [RSZ-1:0]    dc_wr_data, dc_ack_data;
    logic              mem_req, mem_wr, mem_src, mem_ack, mem_ack_fault;
    logic [PC_SZ-1:0]  mem_addr;
    logic [RSZ-1:0]    mem_wr_data;
    logic [LW-1:0]     mem_ack_data;

    l1_mem_arb #(.PC_SZ(PC_SZ), .RSZ(RSZ), .CL_LEN(CL_LEN), .TIMEOUT_CYC(TO)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
        .ic_ack_data(ic_ack_data), .ic_ack_fault(ic_ack_fault),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_wr(dc_wr), .dc_wr_data(dc_wr_data),
        .dc_ack(dc_ack), .dc_ack_data(dc_ack_data), .dc_ack_fault(dc_ack_fault),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
        .mem_src(mem_src), .mem_ack(mem_ack), .mem_ack_data(mem_ack_data),
        .mem_ack_fault(mem_ack_fault)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction model: 0 = no transaction, 1 = bus owned, 2 = response cycle
    int              m_st;
    bit              m_own;   // 0 = I$, 1 = D$
    bit              m_last;
    logic [31:0]     m_addr, m_wdata;
    bit              m_wr;
    logic [LW-1:0]   m_rdata;
    bit              m_rfault;
    int              m_wd;
    bit              ic_wait, dc_wait;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic model_step();
        int idx;
        case (m_st)
            0: if (ic_req || dc_req) begin
                if (ic_req && dc_req) m_own = !m_last;
                else                  m_own = dc_req;
                if (!m_own) begin
                    m_addr = ic_addr; m_wr = 1'b0; m_wdata = '0;
                end else begin
                    m_addr = dc_addr; m_wr = dc_wr; m_wdata = dc_wr_data;
                end
                m_wd = 0;
                m_st = 1;
            end
            1: begin
                if (mem_ack) begin
                    m_st     = 2;
                    m_last   = m_own;
                    m_rfault = mem_ack_fault;
                    idx      = int'((m_addr / 4) % WORDS);
                    m_rdata  = m_own ? LW'(mem_ack_data[idx*32 +: 32]) : mem_ack_data;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (m_wd == TO) begin
                    m_st = 2; m_last = m_own; m_rfault = 1'b1; m_rdata = '0;
                end else begin
                    m_wd++;
                end
`endif
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic check_outputs();
        bit ic_resp, dc_resp;
        ic_resp = (m_st == 2) && !m_own;
        dc_resp = (m_st == 2) && m_own;
        chk("mem_req", LW'(mem_req), LW'(m_st == 1));
        if (m_st == 1) begin
            chk("mem_src", LW'(mem_src), LW'(m_own));
            chk("mem_addr", LW'(mem_addr), LW'(m_addr));
            chk("mem_wr", LW'(mem_wr), LW'(m_wr));
            chk("mem_wr_data", LW'(mem_wr_data), LW'(m_wdata));
        end
        chk("ic_ack", LW'(ic_ack), LW'(ic_resp));
        chk("dc_ack", LW'(dc_ack), LW'(dc_resp));
        chk("ic_ack_data", ic_ack_data, ic_resp ? m_rdata : '0);
        chk("ic_ack_fault", LW'(ic_ack_fault), LW'(ic_resp && m_rfault));
        chk("dc_ack_data", LW'(dc_ack_data), dc_resp ? LW'(m_rdata[31:0]) : '0);
        chk("dc_ack_fault", LW'(dc_ack_fault), LW'(dc_resp && m_rfault));
    endtask

    task automatic new_ic();
        ic_req = 1'b1; ic_addr = $urandom & ~32'(CL_LEN - 1); ic_wait = 1'b1;
    endtask

    task automatic new_dc();
        dc_req = 1'b1; dc_addr = $urandom & ~32'h3; dc_wr = $urandom_range(0, 1);
        dc_wr_data = $urandom; dc_wait = 1'b1;
    endtask

    task automatic drive_step(input bit sat);
        logic [LW-1:0] line;
        if (m_st == 1) begin
            mem_ack = ($urandom_range(0, 2) == 0);
        end else begin
            mem_ack = ($urandom_range(0, 7) == 0);
        end
        line = rand_line();
        if (m_st == 1 && m_own && m_addr == 32'h200C) line[127:96] = 32'hDEADBEEF;
        mem_ack_data  = line;
        mem_ack_fault = ($urandom_range(0, 7) == 0);

        if (m_st == 2 && !m_own) begin
            ic_wait = 1'b0; ic_req = 1'b0;
            if (sat || $urandom_range(0, 1) == 1) new_ic();
        end else if (!ic_wait) begin
            if (sat || $urandom_range(0, 2) == 0) new_ic();
        end else if (!sat && m_st == 1 && !m_own && $urandom_range(0, 63) == 0) begin
            ic_req = 1'b0;
        end

        if (m_st == 2 && m_own) begin
            dc_wait = 1'b0; dc_req = 1'b0;
            if (sat || $urandom_range(0, 1) == 1) new_dc();
        end else if (!dc_wait) begin
            if (sat || $urandom_range(0, 2) == 0) new_dc();
        end else if (!sat && m_st == 1 && m_own && $urandom_range(0, 63) == 0) begin
            dc_req = 1'b0;
        end
    endtask

    initial begin
        bit got;
        rst_n_in = 1'b0;
        ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_addr = '0; dc_wr = 1'b0; dc_wr_data = '0;
        mem_ack = 1'b0; mem_ack_data = '0; mem_ack_fault = 1'b0;
        ic_wait = 1'b0; dc_wait = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_mem_req", LW'(mem_req), '0);
        chk("rst_mem_addr", LW'(mem_addr), '0);
        chk("rst_ic_ack", LW'(ic_ack), '0);
        chk("rst_dc_ack", LW'(dc_ack), '0);
        chk("rst_ic_data", ic_ack_data, '0);

        // Start a D$ write, then pull reset while the bus is owned.
        rst_n_in = 1'b1;
        dc_req = 1'b1; dc_addr = 32'h200C; dc_wr = 1'b1; dc_wr_data = 32'h12345678;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk_in);
            #1;
            if (mem_req) got = 1'b1;
        end
        chk("grant_wait", LW'(got), LW'(1));
        chk("wr_src", LW'(mem_src), LW'(1));
        chk("wr_addr", LW'(mem_addr), LW'(32'h200C));
        chk("wr_flag", LW'(mem_wr), LW'(1));
        chk("wr_data", LW'(mem_wr_data), LW'(32'h12345678));
        @(posedge clk_in);
        #1;
        chk("wr_hold", LW'(mem_wr_data), LW'(32'h12345678));
        #2 rst_n_in = 1'b0;
        #1;
        chk("async_mem_req", LW'(mem_req), '0);
        chk("async_mem_src", LW'(mem_src), '0);
        chk("async_mem_addr", LW'(mem_addr), '0);
        chk("async_mem_wr", LW'(mem_wr), '0);
        chk("async_mem_wr_data", LW'(mem_wr_data), '0);
        chk("async_acks", LW'({ic_ack, dc_ack}), '0);

        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        new_ic();
        dc_req = 1'b1; dc_addr = 32'h200C; dc_wr = 1'b0; dc_wait = 1'b1;
        m_st = 0; m_last = 1'b1; m_own = 1'b0; m_rfault = 1'b0; m_rdata = '0; m_wd = 0;
        m_addr = '0; m_wdata = '0; m_wr = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk_in);
            #1;
            model_step();
            check_outputs();
            drive_step(cyc >= NCYC / 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
